// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter slice.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEFAULT          = 3;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request after last_grant, wrapping.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int GW    = width_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last_grant,
    output logic [GW-1:0]    winner,
    output logic             any_req
);

    int   idx_s;
    logic hit_s;

    // Scan requesters starting one past the previous owner; the first hit wins.
    always_comb begin
        winner  = last_grant;
        any_req = 1'b0;
        idx_s   = 0;
        hit_s   = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s   = (int'(last_grant) + i) % N_REQ;
            hit_s   = req[idx_s] & ~any_req;
            winner  = hit_s ? GW'(idx_s) : winner;
            any_req = any_req | req[idx_s];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-locked round-robin arbiter sharing one UART transmitter among N_REQ
// byte streams, with forced release after TIMEOUT_CYCLES idle cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = N_REQ_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][7:0]         req_data,
    input  logic [N_REQ-1:0]              req_last,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          uart_tx_valid,
    output logic [7:0]                    uart_tx_data,
    input  logic                          uart_tx_ready,
    output logic [width_min1(N_REQ)-1:0]  grant_id,
    output logic                          busy,
    output logic                          timeout_pulse
);

    localparam int GW = width_min1(N_REQ);
    localparam int CW = width_min1(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    arb_state_e    state_r;
    logic [GW-1:0] last_grant_r;
    logic [CW-1:0] idle_cnt_r;
    logic [GW-1:0] winner_s;
    logic          any_req_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .winner     (winner_s),
        .any_req    (any_req_s)
    );

    // Owner's stream is passed straight through so the UART sees no extra latency.
    always_comb begin
        uart_tx_valid = 1'b0;
        uart_tx_data  = 8'h00;
        req_ready     = '0;
        if (state_r == LOCKED) begin
            uart_tx_valid       = req_valid[grant_id];
            uart_tx_data        = req_data[grant_id];
            req_ready[grant_id] = uart_tx_ready;
        end else begin
            uart_tx_valid = 1'b0;
            uart_tx_data  = 8'h00;
            req_ready     = '0;
        end
    end

    // Arbitration FSM; a stalled UART keeps valid high, which holds the idle counter at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            grant_id      <= '0;
            last_grant_r  <= GW'(N_REQ - 1);
            idle_cnt_r    <= '0;
            timeout_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r    <= LOCKED;
                        grant_id   <= winner_s;
                        idle_cnt_r <= '0;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (req_valid[grant_id]) begin
                        idle_cnt_r <= '0;
                        if (uart_tx_ready && req_last[grant_id]) begin
                            state_r      <= IDLE;
                            last_grant_r <= grant_id;
                            busy         <= 1'b0;
                        end else begin
                            busy <= 1'b1;
                        end
                    end else if (idle_cnt_r == CNT_MAX) begin
                        state_r       <= IDLE;
                        last_grant_r  <= grant_id;
                        idle_cnt_r    <= '0;
                        timeout_pulse <= 1'b1;
                        busy          <= 1'b0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-stream sources feed the DUT and a
// queue of expected {requester, byte} pairs is checked at every UART transfer.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0][7:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            uart_tx_valid;
    logic [7:0]      uart_tx_data;
    logic            uart_tx_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_pulse;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    logic [8:0] src_q [N][$];
    logic [9:0] exp_q [$];
    logic [N-1:0] en;
    int checks = 0;
    int failures = 0;
    int xfer_cnt, busy_cnt, lidle_cnt, pulse_cnt, cyc, first_xfer, last_xfer;
    logic busy_smp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_byte(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({last, d});
        exp_q.push_back({2'(r), d});
    endtask

    task automatic drive();
        logic [8:0] head;
        for (int r = 0; r < N; r++) begin
            if (en[r] && src_q[r].size() > 0) begin
                head         = src_q[r][0];
                req_valid[r] = 1'b1;
                req_last[r]  = head[8];
                req_data[r]  = head[7:0];
            end else begin
                req_valid[r] = 1'b0;
                req_last[r]  = 1'b0;
                req_data[r]  = 8'h00;
            end
        end
    endtask

    function automatic logic pending();
        logic p;
        p = 1'b0;
        for (int r = 0; r < N; r++) p = p | (src_q[r].size() > 0);
        return p;
    endfunction

    task automatic reset_counters();
        xfer_cnt = 0; busy_cnt = 0; lidle_cnt = 0; pulse_cnt = 0;
        cyc = 0; first_xfer = 0; last_xfer = 0;
    endtask

    // One clock: observe at the falling edge, advance sources after the rising edge.
    task automatic step();
        logic [N-1:0] hs;
        logic [N-1:0] er;
        logic [9:0]   e;
        @(negedge clk);
        hs       = req_valid & req_ready;
        busy_smp = busy;
        er       = busy ? (N'(uart_tx_ready) << grant_id) : '0;
        check("req_ready", 32'(req_ready), 32'(er));
        if (!busy) check("tx_idle", 32'({uart_tx_valid, uart_tx_data}), 32'd0);
        if (uart_tx_valid && uart_tx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'({grant_id, uart_tx_data}), 32'h3ff);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", 32'({grant_id, uart_tx_data}), 32'(e));
            end
            if (xfer_cnt == 0) first_xfer = cyc;
            last_xfer = cyc;
            xfer_cnt++;
        end
        if (busy) busy_cnt++;
        if (busy && !uart_tx_valid) lidle_cnt++;
        if (timeout_pulse) pulse_cnt++;
        cyc++;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) if (hs[r]) void'(src_q[r].pop_front());
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || pending()) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),          32'd0);
        check({tag, "_grant"},     32'(grant_id),      32'd0);
        check({tag, "_tx_valid"},  32'(uart_tx_valid), 32'd0);
        check({tag, "_tx_data"},   32'(uart_tx_data),  32'd0);
        check({tag, "_req_ready"}, 32'(req_ready),     32'd0);
        check({tag, "_pulse"},     32'(timeout_pulse), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; uart_tx_ready = 1'b1; en = '1;
        req_valid = '0; req_data = '0; req_last = '0;
        reset_counters();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round robin from requester 0 with everyone requesting: 0,1,2,0.
        reset_counters();
        for (int i = 0; i < 3; i++) load_byte(0, 8'(8'h10 + i), i == 2);
        for (int i = 0; i < 3; i++) load_byte(1, 8'(8'h20 + i), i == 2);
        for (int i = 0; i < 3; i++) load_byte(2, 8'(8'h30 + i), i == 2);
        for (int i = 0; i < 3; i++) load_byte(0, 8'(8'h13 + i), i == 2);
        drive();
        drain(200);
        check("rr_xfers", 32'(xfer_cnt), 32'd12);

        // Single-byte frame: busy for exactly one cycle.
        reset_counters();
        load_byte(0, 8'h5a, 1'b1);
        drive();
        drain(20);
        step();
        step();
        check("single_busy_cycles", 32'(busy_cnt), 32'd1);
        check("single_xfers", 32'(xfer_cnt), 32'd1);

        // 26-byte frame ending in newline, back-to-back transfers.
        reset_counters();
        for (int i = 0; i < 25; i++) load_byte(0, 8'(8'h41 + i), 1'b0);
        load_byte(0, 8'h0a, 1'b1);
        drive();
        drain(100);
        step();
        check("frame_busy_drop", 32'(busy_smp), 32'd0);
        check("frame_xfers", 32'(xfer_cnt), 32'd26);
        check("frame_span", 32'(last_xfer - first_xfer + 1), 32'd26);

        // Long UART stall must not count as idle.
        reset_counters();
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) load_byte(1, 8'(8'hb0 + i), i == 3);
        drive();
        repeat (2000) step();
        check("stall_no_pulse", 32'(pulse_cnt), 32'd0);
        check("stall_busy", 32'(busy_smp), 32'd1);
        check("stall_grant", 32'(grant_id), 32'd1);
        check("stall_no_xfer", 32'(xfer_cnt), 32'd0);
        uart_tx_ready = 1'b1;
        drain(50);
        check("stall_xfers", 32'(xfer_cnt), 32'd4);

        // Requester 2 goes quiet mid-frame and is forced off.
        reset_counters();
        load_byte(2, 8'hc3, 1'b0);
        drive();
        n = 0;
        while (pulse_cnt == 0 && n < 100) begin
            step();
            n++;
        end
        check("timeout_seen", 32'(pulse_cnt), 32'd1);
        check("timeout_idle_cycles", 32'(lidle_cnt), 32'(TO));
        repeat (3) step();
        check("timeout_once", 32'(pulse_cnt), 32'd1);
        check("timeout_fsm_idle", 32'(busy_smp), 32'd0);
        load_byte(0, 8'hd0, 1'b1);
        load_byte(1, 8'he0, 1'b1);
        drive();
        drain(20);

        // Reset in the middle of a requester 1 frame.
        reset_counters();
        for (int i = 0; i < 10; i++) load_byte(1, 8'(8'h60 + i), i == 9);
        drive();
        n = 0;
        while (xfer_cnt < 5 && n < 50) begin
            step();
            n++;
        end
        check("pre_reset_xfers", 32'(xfer_cnt), 32'd5);
        reset = 1'b1;
        en = '0;
        drive();
        step();
        @(negedge clk);
        check_reset_outputs("mid_reset");
        check("mid_reset_no_pulse", 32'(pulse_cnt), 32'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        for (int r = 0; r < N; r++) src_q[r].delete();
        load_byte(0, 8'h70, 1'b0);
        load_byte(0, 8'h71, 1'b1);
        load_byte(1, 8'h80, 1'b1);
        reset = 1'b0;
        en = '1;
        drive();
        drain(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
